// File: rtl/pc_redirect_ctrl.sv
// ---------------------------------------------------------------------------
// pc_redirect_ctrl
//
// Purpose:
//   Fetch-PC redirect and hazard controller for a short in-order pipeline.
//   It arbitrates between an EX-stage taken branch, an ID-stage jump, an
//   instruction-memory stall and a load-use hazard. It produces the fetch-PC
//   select and redirect address, and the fetch-hold and pipeline-kill
//   controls. A taken branch that resolves while fetch is frozen is parked
//   in a pending register and issued once the stall clears.
//
// Parameters:
//   TRAP_VECTOR  redirect target for misaligned jumps when the trap feature
//                is compiled in.
//
// Configuration macro:
//   REDIRECT_MISALIGN_TRAP_EN
//     defined -> a misaligned redirect goes to TRAP_VECTOR.
//     absent  -> a misaligned redirect has its low two bits cleared.
//
// Ports:
//   CLK         in   clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   ExBrTaken   in   EX-stage branch resolved taken
//   ExBrTarget  in   [31:0] EX-stage branch target
//   IdJump      in   ID-stage unconditional jump decoded
//   IdJTarget   in   [31:0] ID-stage jump target
//   LoadUse     in   ID-stage load-use hazard
//   ExtStall    in   instruction memory not ready, pipeline frozen
//   PCS         out  1 = load JADDR as the next fetch PC
//   JADDR       out  [31:0] redirect address (0 when PCS = 0)
//   Flush       out  hold the fetch PC
//   FlushBack   out  hold the fetch PC and replay the previous PC
//   IFIDFlush   out  kill the IF/ID register
//   IDEXFlush   out  insert a bubble into ID/EX
//   Misalign    out  the issued redirect target had bits [1:0] != 0
//   RedirCnt    out  [15:0] count of issued redirects, wraps
// ---------------------------------------------------------------------------
module pc_redirect_ctrl #(
    parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100
) (
    input  logic        CLK,
    input  logic        rst_n,
    input  logic        ExBrTaken,
    input  logic [31:0] ExBrTarget,
    input  logic        IdJump,
    input  logic [31:0] IdJTarget,
    input  logic        LoadUse,
    input  logic        ExtStall,
    output logic        PCS,
    output logic [31:0] JADDR,
    output logic        Flush,
    output logic        FlushBack,
    output logic        IFIDFlush,
    output logic        IDEXFlush,
    output logic        Misalign,
    output logic [15:0] RedirCnt
);

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    state_t      state_reg;
    state_t      state_next;
    logic        pend_valid_reg;
    logic        pend_valid_next;
    logic [31:0] pend_target_reg;
    logic [31:0] pend_target_next;
    logic [15:0] redir_cnt_reg;

    // Raw redirect decision and its un-sanitised target.
    logic        redir;
    logic [31:0] redir_target;
    logic        flush_raw;
    logic        flush_back_raw;
    logic        ifid_flush;
    logic        idex_flush;
    logic        misalign;

    // -----------------------------------------------------------------------
    // Next-state and output decode
    // -----------------------------------------------------------------------
    always_comb begin
        state_next       = state_reg;
        pend_valid_next  = pend_valid_reg;
        pend_target_next = pend_target_reg;
        redir            = 1'b0;
        redir_target     = 32'h0;
        flush_raw        = 1'b0;
        flush_back_raw   = 1'b0;
        ifid_flush       = 1'b0;
        idex_flush       = 1'b0;

        case (state_reg)
            RUN: begin
                if (ExBrTaken) begin
                    if (!ExtStall) begin
                        redir        = 1'b1;
                        redir_target = ExBrTarget;
                        ifid_flush   = 1'b1;
                        idex_flush   = 1'b1;
                    end else begin
                        // Branch resolved while fetch is frozen: park it
                        // and replay the previous PC until memory is ready.
                        pend_target_next = ExBrTarget;
                        pend_valid_next  = 1'b1;
                        flush_back_raw   = 1'b1;
                        state_next       = STALL;
                    end
                end else if (ExtStall) begin
                    // A stall outranks the ID jump and the load-use hazard;
                    // both are re-presented once the pipeline unfreezes.
                    flush_back_raw = 1'b1;
                    state_next     = STALL;
                end else if (IdJump) begin
                    redir        = 1'b1;
                    redir_target = IdJTarget;
                    ifid_flush   = 1'b1;
                end else if (LoadUse) begin
                    flush_raw  = 1'b1;
                    idex_flush = 1'b1;
                end
            end

            STALL: begin
                if (ExtStall) begin
                    flush_raw = 1'b1;
                    // Only the first branch seen during the stall is kept.
                    if (ExBrTaken && !pend_valid_reg) begin
                        pend_target_next = ExBrTarget;
                        pend_valid_next  = 1'b1;
                    end
                end else begin
                    state_next = RUN;
                    if (pend_valid_reg) begin
                        redir           = 1'b1;
                        redir_target    = pend_target_reg;
                        ifid_flush      = 1'b1;
                        idex_flush      = 1'b1;
                        pend_valid_next = 1'b0;
                    end
                end
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Redirect address sanitising
    // -----------------------------------------------------------------------
    assign misalign = redir && (redir_target[1:0] != 2'b00);

`ifdef REDIRECT_MISALIGN_TRAP_EN
    always_comb begin
        if (!redir) begin
            JADDR = 32'h0;
        end else if (misalign) begin
            JADDR = TRAP_VECTOR;
        end else begin
            JADDR = redir_target;
        end
    end
`else
    // TRAP_VECTOR only matters when the trap feature is compiled in.
    logic unused_trap_vector;
    assign unused_trap_vector = ^TRAP_VECTOR;

    always_comb begin
        if (!redir) begin
            JADDR = 32'h0;
        end else begin
            JADDR = {redir_target[31:2], 2'b00};
        end
    end
`endif

    // A redirect overrides any hold of the fetch PC.
    assign PCS       = redir;
    assign Flush     = flush_raw && !redir;
    assign FlushBack = flush_back_raw && !redir;
    assign IFIDFlush = ifid_flush;
    assign IDEXFlush = idex_flush;
    assign Misalign  = misalign;
    assign RedirCnt  = redir_cnt_reg;

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= RUN;
            pend_valid_reg  <= 1'b0;
            pend_target_reg <= 32'h0;
            redir_cnt_reg   <= 16'h0;
        end else begin
            state_reg       <= state_next;
            pend_valid_reg  <= pend_valid_next;
            pend_target_reg <= pend_target_next;
            if (redir) begin
                redir_cnt_reg <= redir_cnt_reg + 16'd1;
            end
        end
    end

endmodule
